// File: rtl/complex_alu_pkg.sv
// complex_alu_pkg
// Shared types for the sequenced real/complex ALU:
//   op_t    - operation encodings carried on the op field (11x is illegal)
//   state_t - sequencer states, also exported on the bus for observation
package complex_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHR = 3'b100,
        OP_SHL = 3'b101
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_MUL2,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/complex_alu_seq_if.sv
// complex_alu_seq_if
// Request/result bus between the operand source (master) and the ALU (slave).
//   start, op, is_complex, a_re, a_im, b_re, b_im : request, master -> slave
//   busy, done, y_re, y_im, err                   : status/result, slave -> master
//   state                                          : sequencer state, observation only
//
// Handshake: the slave samples start (with op and operands) only while busy=0.
// An accepted request raises busy on the following cycle; busy stays high
// through the done cycle, so the earliest next request is the cycle after done.
// done is a single-cycle pulse; y_re/y_im/err are valid from that cycle and
// are held until the next done. A start seen while busy=1 is dropped.
interface complex_alu_seq_if
    import complex_alu_pkg::*;
#(
    parameter int W = 16
);

    logic           start;
    logic [2:0]     op;
    logic           is_complex;
    logic [W-1:0]   a_re;
    logic [W-1:0]   a_im;
    logic [W-1:0]   b_re;
    logic [W-1:0]   b_im;
    logic           busy;
    logic           done;
    logic [2*W-1:0] y_re;
    logic [2*W-1:0] y_im;
    logic           err;
    state_t         state;

    modport master (
        output start, op, is_complex, a_re, a_im, b_re, b_im,
        input  busy, done, y_re, y_im, err, state
    );

    modport slave (
        input  start, op, is_complex, a_re, a_im, b_re, b_im,
        output busy, done, y_re, y_im, err, state
    );

endinterface

// File: rtl/complex_alu_seq_divider.sv
// seq_divider
// W-bit unsigned restoring divider, one quotient bit per step.
//   clk, rst            : clock, synchronous active-high reset (clears all registers)
//   load                : capture dividend/divisor, clear remainder and count
//   step                : perform one restoring iteration
//   dividend, divisor   : operands, sampled on load
//   quotient, remainder : results, final after W steps
//   count               : number of steps taken since load
module seq_divider #(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [W-1:0]       dividend,
    input  logic [W-1:0]       divisor,
    output logic [W-1:0]       quotient,
    output logic [W-1:0]       remainder,
    output logic [$clog2(W):0] count
);

    logic [W-1:0]       quo;
    logic [W-1:0]       rem;
    logic [W-1:0]       dvs;
    logic [$clog2(W):0] cnt;
    logic [W:0]         trial;
    logic [W:0]         diff;

    // trial < 2*divisor, so a non-negative difference always fits W bits and
    // bit W of diff acts as the borrow.
    always_comb begin
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
            cnt <= '0;
        end else if (step) begin
            if (!diff[W]) begin
                rem <= diff[W-1:0];
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= trial[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign count     = cnt;

endmodule

// File: rtl/complex_alu_seq.sv
// complex_alu_seq
// Handshaked real/complex ALU: add, sub, mul, div, shr, shl on W-bit lanes,
// sequenced by an FSM and reported with a single-cycle done pulse.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset; aborts any operation without done
//   bus : complex_alu_seq_if.slave (request, status, results, state)
// Build option: COMPLEX_ALU_SAT_EN - add/sub saturate to the signed W-bit range
// and shl to the unsigned W-bit max before extension; mul/div unchanged.
module complex_alu_seq
    import complex_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    complex_alu_seq_if.slave bus
);

    localparam int SHW = $clog2(W);
    localparam logic [SHW:0] DIV_STEPS = (SHW+1)'(W);

    state_t         state, state_nxt;
    logic [2:0]     op_r;
    logic           cplx_r;
    logic [W-1:0]   a_re_r, a_im_r, b_re_r, b_im_r;
    logic [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic [2*W-1:0] y_re_r, y_im_r;
    logic           err_r;
    logic [2*W-1:0] exec_re, exec_im;
    logic           exec_err;
    logic           accept, div_load, div_step, div_zero, div_done;
    logic [W-1:0]   q_re, q_im, r_re, r_im_unused;
    logic [SHW:0]   cnt_re, cnt_im;
    logic [SHW-1:0] shamt;

    function automatic logic [2*W-1:0] lane_addsub(input logic [W-1:0] a,
                                                   input logic [W-1:0] b,
                                                   input logic sub);
        logic [W:0] s;
        s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
`ifdef COMPLEX_ALU_SAT_EN
        // Overflow of the W-bit signed range shows as bit W != bit W-1.
        if (s[W] != s[W-1])
            s = s[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
`endif
        return {{(W-1){s[W]}}, s};
    endfunction

    function automatic logic [2*W-1:0] lane_shl(input logic [W-1:0] a,
                                                input logic [SHW-1:0] n);
        logic [2*W-1:0] r;
        r = {{W{1'b0}}, a} << n;
`ifdef COMPLEX_ALU_SAT_EN
        if (|r[2*W-1:W])
            r = {{W{1'b0}}, {W{1'b1}}};
`endif
        return r;
    endfunction

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ax, bx;
        ax = {{W{a[W-1]}}, a};
        bx = {{W{b[W-1]}}, b};
        return ax * bx;
    endfunction

    assign accept   = (state == S_IDLE) && bus.start;
    assign div_load = accept && (bus.op == OP_DIV);
    assign div_zero = (b_re_r == '0);
    assign div_done = (cnt_re == DIV_STEPS) && (cnt_im == DIV_STEPS);
    assign div_step = (state == S_DIV) && !div_zero && !div_done;
    assign shamt    = b_re_r[SHW-1:0];

    // Both lanes share the real divisor; the im-lane remainder has no destination.
    seq_divider #(.W(W)) u_div_re (
        .clk(clk), .rst(rst), .load(div_load), .step(div_step),
        .dividend(bus.a_re), .divisor(bus.b_re),
        .quotient(q_re), .remainder(r_re), .count(cnt_re)
    );

    seq_divider #(.W(W)) u_div_im (
        .clk(clk), .rst(rst), .load(div_load), .step(div_step),
        .dividend(bus.a_im), .divisor(bus.b_re),
        .quotient(q_im), .remainder(r_im_unused), .count(cnt_im)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MUL:  state_nxt = S_MUL;
                        OP_DIV:  state_nxt = S_DIV;
                        default: state_nxt = S_EXEC;
                    endcase
                end
            end
            S_EXEC:  state_nxt = S_DONE;
            S_MUL:   state_nxt = S_MUL2;
            S_MUL2:  state_nxt = S_DONE;
            S_DIV:   if (div_zero || div_done) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        exec_re  = '0;
        exec_im  = '0;
        exec_err = 1'b0;
        case (op_r)
            OP_ADD: begin
                exec_re = lane_addsub(a_re_r, b_re_r, 1'b0);
                exec_im = lane_addsub(a_im_r, b_im_r, 1'b0);
            end
            OP_SUB: begin
                exec_re = lane_addsub(a_re_r, b_re_r, 1'b1);
                exec_im = lane_addsub(a_im_r, b_im_r, 1'b1);
            end
            OP_SHR: begin
                exec_re = {{W{1'b0}}, a_re_r >> shamt};
                exec_im = {{W{1'b0}}, a_im_r >> shamt};
            end
            OP_SHL: begin
                exec_re = lane_shl(a_re_r, shamt);
                exec_im = lane_shl(a_im_r, shamt);
            end
            default: exec_err = 1'b1;
        endcase
        if (!cplx_r) exec_im = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= '0;
            cplx_r <= 1'b0;
            a_re_r <= '0;
            a_im_r <= '0;
            b_re_r <= '0;
            b_im_r <= '0;
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
            y_re_r <= '0;
            y_im_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (accept) begin
                op_r   <= bus.op;
                cplx_r <= bus.is_complex;
                a_re_r <= bus.a_re;
                a_im_r <= bus.a_im;
                b_re_r <= bus.b_re;
                b_im_r <= bus.b_im;
            end
            case (state)
                S_EXEC: begin
                    y_re_r <= exec_re;
                    y_im_r <= exec_im;
                    err_r  <= exec_err;
                end
                S_MUL: begin
                    p_rr <= smul(a_re_r, b_re_r);
                    p_ii <= smul(a_im_r, b_im_r);
                    p_ri <= smul(a_re_r, b_im_r);
                    p_ir <= smul(a_im_r, b_re_r);
                end
                S_MUL2: begin
                    y_re_r <= cplx_r ? (p_rr - p_ii) : p_rr;
                    y_im_r <= cplx_r ? (p_ri + p_ir) : '0;
                    err_r  <= 1'b0;
                end
                S_DIV: begin
                    if (div_zero) begin
                        y_re_r <= {{W{1'b0}}, {W{1'b1}}};
                        y_im_r <= cplx_r ? {{W{1'b0}}, {W{1'b1}}} : {{W{1'b0}}, a_re_r};
                        err_r  <= 1'b1;
                    end else if (div_done) begin
                        y_re_r <= {{W{1'b0}}, q_re};
                        y_im_r <= cplx_r ? {{W{1'b0}}, q_im} : {{W{1'b0}}, r_re};
                        err_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_DONE);
    assign bus.y_re  = y_re_r;
    assign bus.y_im  = y_im_r;
    assign bus.err   = err_r;
    assign bus.state = state;

endmodule

// File: doc/complex_alu_seq.md
Name: complex_alu_seq

Overview:
- Parametrised, handshaked successor of the combinational-select real/complex arithmetic unit.
- Takes one operation per request (add, sub, mul, div, shift right, shift left) on real or complex operands of width W.
- Runs multi-cycle operations through an internal sequencer and reports completion with a done pulse.
- Sits between the operand/command source and the result consumer in the lab datapath.

Parameters:
- W, 16: operand width per real/imaginary component; must be ≥ 4 and a power of two.
- SHW, $clog2(W): shift-amount width, derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled only when busy=0.
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 shr, 101 shl, 11x illegal.
- is_complex  in  1  1 = complex operands, 0 = real (re lanes only).
- a_re, a_im, b_re, b_im  in  W  operands, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; y_re/y_im/err valid from this cycle.
- y_re, y_im  out  2W  results, held until the next done.
- err  out  1  set with done for an illegal op or divide-by-zero; otherwise 0.

Behaviour:
- Reset: state IDLE; busy, done and err = 0; y_re and y_im = 0; divider registers cleared.
- Reset mid-operation aborts to IDLE with no done pulse.
- Accept: start=1 in IDLE captures op, is_complex and all operands into registers. Start while busy is ignored and is not queued.
- FSM states:
  - IDLE -> EXEC for add/sub/shr/shl/illegal.
  - IDLE -> MUL for mul.
  - IDLE -> DIV for div.
  - EXEC -> DONE.
  - MUL -> MUL2 -> DONE.
  - DIV loops W cycles -> DONE.
  - DONE -> IDLE; done=1 while in DONE.
- Latency (start cycle to done cycle): add/sub/shift/illegal 2, mul 3, div W+2.
- Back-to-back: start is accepted in the cycle after done, at the earliest.
- add/sub: signed two's complement, computed in W+1 bits, sign-extended to 2W.
  - Complex: re and im lanes are independent.
  - Real: y_im = 0.
- mul: signed.
  - Real: y_re = a_re*b_re; y_im = 0.
  - Complex: y_re = a_re*b_re − a_im*b_im; y_im = a_re*b_im + a_im*b_re.
  - Products are computed at full 2W width and wrap at 2W.
  - The MUL stage registers the four partial products; MUL2 performs the sum/difference.
- div: unsigned restoring, one quotient bit per cycle, two lanes in parallel.
  - Real: y_re = a_re / b_re, y_im = a_re % b_re.
  - Complex: y_re = a_re / b_re, y_im = a_im / b_re (division by a real scalar).
  - Results are zero-extended.
  - b_re = 0: no iteration; go straight to DONE (latency 2), err=1, quotients all-ones (W bits), remainder = dividend.
- shr/shl: logical; amount = b_re[SHW-1:0], applied to a_re (and to a_im when complex).
  - shr result is zero-extended.
  - shl is computed in 2W bits, so no bits are lost.
  - Real: y_im = 0.
- Illegal op: y_re = y_im = 0, err = 1, latency 2.

Optional Feature:
- Macro: COMPLEX_ALU_SAT_EN.
- Defined: add, sub and shl results saturate to the signed W-bit range (shl to the unsigned W-bit max) before extension to 2W. Mul and div are unchanged.
- Undefined: full-width results as specified above.

Decomposition:
- Package complex_alu_pkg holds:
  - op encodings as typedef enum logic [2:0] (OP_ADD … OP_SHL);
  - the FSM state enum (S_IDLE, S_EXEC, S_MUL, S_MUL2, S_DIV, S_DONE).
- One sub-module: seq_divider, a W-bit unsigned restoring single-lane divider with load/step/count and quotient/remainder outputs. It is instantiated twice (re and im lanes).

Test Plan (all with W=16):
- Complex add: a=(0x7FFF, −1), b=(1, −1), op=000 -> done at start+2; y_re=0x0000_8000, y_im=0xFFFF_FFFE, err=0. Repeat with COMPLEX_ALU_SAT_EN -> y_re=0x0000_7FFF.
- Complex mul: (3+4i)*(1+2i) -> done at start+3; y_re=−5 (0xFFFF_FFFB), y_im=10.
- Real div: a_re=100, b_re=7 -> done at start+18; y_re=14, y_im=2, err=0. Same operands with start pulsed again at start+5 -> ignored, exactly one done.
- Divide by zero: a_re=0x1234, b_re=0 -> done at start+2; y_re=0x0000_FFFF, y_im=0x1234, err=1.
- Shifts: a_re=0x8001, b_re=4; shl -> y_re=0x0008_0010; shr -> y_re=0x0000_0800.
- Reset at start+6 of a div: -> next cycle busy=0, done=0, y_re=y_im=0; a new add is accepted immediately and completes at its start+2.
